// File: rtl/vga_pkg.sv
// Shared VGA timing, framebuffer address format and capture state encoding.
// Used by both the timing generator and the capture block.
package vga_pkg;

  localparam int unsigned H_VISIBLE_AREA = 640;
  localparam int unsigned H_FRONT_PORCH  = 16;
  localparam int unsigned H_SYNC_PULSE   = 96;
  localparam int unsigned H_BACK_PORCH   = 48;
  localparam int unsigned V_VISIBLE_AREA = 480;
  localparam int unsigned V_FRONT_PORCH  = 10;
  localparam int unsigned V_SYNC_PULSE   = 2;
  localparam int unsigned V_BACK_PORCH   = 33;
  localparam int unsigned PIXEL_DELAY    = 1;

  localparam int unsigned H_WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int unsigned V_WHOLE_FRAME = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int unsigned XS = H_SYNC_PULSE + H_FRONT_PORCH + PIXEL_DELAY;
  localparam int unsigned YS = V_SYNC_PULSE + V_FRONT_PORCH;

  localparam int unsigned X_W    = 11;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned PIX_W  = 10;
  localparam int unsigned DATA_W = 8;

  // Framebuffer address: {py, px}
  typedef struct packed {
    logic [PIX_W-1:0] y;
    logic [PIX_W-1:0] x;
  } fb_addr_t;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

endpackage

// File: rtl/vga_capture_if.sv
// Video input pins plus framebuffer write port of the capture block.
interface vga_capture_if;
  import vga_pkg::*;

  logic              h_sync;
  logic              v_sync;
  logic [2:0]        red;
  logic [2:0]        green;
  logic [1:0]        blue;
  logic              wr_en;
  fb_addr_t          wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              locked;
  logic              frame_done;
  logic              sync_error;

  modport master (
    output h_sync, v_sync, red, green, blue,
    input  wr_en, wr_addr, wr_data, locked, frame_done, sync_error
  );

  modport slave (
    input  h_sync, v_sync, red, green, blue,
    output wr_en, wr_addr, wr_data, locked, frame_done, sync_error
  );
endinterface

// File: rtl/vga_sync_edge.sv
// Registers one sync line and keeps the previous sample to flag fall/rise.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic fall_c,
  output logic rise_c
);

  logic sample_q, sample_d;
  logic prev_q, prev_d;

  always_comb begin
    sample_d = sync_in;
    prev_d   = sample_q;
  end

  // Both flops idle high so no edge is seen straight out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= 1'b1;
      prev_q   <= 1'b1;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
    end
  end

  assign fall_c = prev_q & ~sample_q;
  assign rise_c = ~prev_q & sample_q;

endmodule

// File: rtl/vga_capture.sv
// Recovers pixel coordinates from incoming VGA syncs, verifies one frame of
// timing, then writes every visible pixel into the framebuffer port.
module vga_capture
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS   = H_VISIBLE_AREA,
  parameter int unsigned H_FP    = H_FRONT_PORCH,
  parameter int unsigned H_SYNC  = H_SYNC_PULSE,
  parameter int unsigned H_BP    = H_BACK_PORCH,
  parameter int unsigned V_VIS   = V_VISIBLE_AREA,
  parameter int unsigned V_FP    = V_FRONT_PORCH,
  parameter int unsigned V_SYNC  = V_SYNC_PULSE,
  parameter int unsigned V_BP    = V_BACK_PORCH,
  parameter int unsigned PIX_DLY = PIXEL_DELAY
) (
  input  logic          clk,
  input  logic          rst,
  vga_capture_if.slave  vid
);

  localparam int unsigned H_WHOLE = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_WHOLE = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned X_START = H_SYNC + H_FP + PIX_DLY;
  localparam int unsigned Y_START = V_SYNC + V_FP;

  logic              h_fall_c, h_rise_c, v_fall_c, v_rise_c;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic              frame_start_c, viol_c, vis_c;
  logic [PIX_W-1:0]  px_c, py_c;
  cap_state_e        state_q, state_d;
  logic              wr_en_q, wr_en_d;
  fb_addr_t          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              locked_q, locked_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_error_q, sync_error_d;

  vga_sync_edge u_h_edge (
    .clk(clk), .rst(rst), .sync_in(vid.h_sync), .fall_c(h_fall_c), .rise_c(h_rise_c)
  );

  vga_sync_edge u_v_edge (
    .clk(clk), .rst(rst), .sync_in(vid.v_sync), .fall_c(v_fall_c), .rise_c(v_rise_c)
  );

  // Sample/line counters, both saturating at one past the last legal value
  always_comb begin
    rgb_d         = {vid.red, vid.green, vid.blue};
    frame_start_c = h_fall_c & v_fall_c;
    if (h_fall_c)                    x_d = '0;
    else if (x_q == X_W'(H_WHOLE))   x_d = x_q;
    else                             x_d = x_q + X_W'(1);
    if (frame_start_c)                             y_d = '0;
    else if (h_fall_c && (y_q != Y_W'(V_WHOLE)))   y_d = y_q + Y_W'(1);
    else                                           y_d = y_q;
  end

  always_comb begin
    viol_c = (h_fall_c && (x_q != X_W'(H_WHOLE - 1)))
          || (x_d == X_W'(H_WHOLE))
          || (h_rise_c && (x_d != X_W'(H_SYNC)))
          || (frame_start_c && (y_q != Y_W'(V_WHOLE - 1)))
          || (y_d == Y_W'(V_WHOLE))
          || (v_rise_c && h_fall_c && (y_d != Y_W'(V_SYNC)))
          || ((v_fall_c || v_rise_c) && !h_fall_c);
    vis_c  = (x_d >= X_W'(X_START)) && (x_d < X_W'(X_START + H_VIS))
          && (y_d >= Y_W'(Y_START)) && (y_d < Y_W'(Y_START + V_VIS));
    px_c   = PIX_W'(x_d - X_W'(X_START));
    py_c   = PIX_W'(y_d - Y_W'(Y_START));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= X_W'(H_WHOLE);
      y_q   <= Y_W'(V_WHOLE);
      rgb_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      rgb_q <= rgb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  // A violation on a frame-start sample wins over CHECK -> LOCKED
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (frame_start_c) state_d = CHECK;
      CHECK:   if (viol_c) state_d = SEARCH;
               else if (frame_start_c) state_d = LOCKED;
      LOCKED:  if (viol_c) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked_d     = (state_d == LOCKED);
    wr_en_d      = locked_d && vis_c;
    sync_error_d = (state_q != SEARCH) && viol_c;
    frame_done_d = wr_en_d && (px_c == PIX_W'(H_VIS - 1)) && (py_c == PIX_W'(V_VIS - 1));
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d.y = py_c;
      wr_addr_d.x = px_c;
      wr_data_d   = rgb_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign vid.wr_en      = wr_en_q;
  assign vid.wr_addr    = wr_addr_q;
  assign vid.wr_data    = wr_data_q;
  assign vid.locked     = locked_q;
  assign vid.frame_done = frame_done_q;
  assign vid.sync_error = sync_error_q;

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA timing generator: samples an incoming 640x480@60 stream (h_sync, v_sync, 3-3-2 RGB) on the pixel clock and recovers pixel coordinates from the sync edges. Once it has verified one full frame of correct timing, it emits one write per visible pixel into a framebuffer port using the same 20-bit {y, x} address format the generator reads. It sits between a video input (or the generator, in loopback) and framebuffer memory.

## Interface
- H_VISIBLE_AREA, 640; H_FRONT_PORCH, 16; H_SYNC_PULSE, 96; H_BACK_PORCH, 48: horizontal timing in pixels.
- V_VISIBLE_AREA, 480; V_FRONT_PORCH, 10; V_SYNC_PULSE, 2; V_BACK_PORCH, 33: vertical timing in lines.
- H_WHOLE_LINE, 800, and V_WHOLE_FRAME, 525: derived sums of the four timing values.
- PIXEL_DELAY, 1: delay in samples from the sync timebase to RGB validity (the generator registers RGB once).
- clk  in  1  pixel clock, same domain as the source; reset rst: asynchronous, active-high.
- rst  in  1  asynchronous active-high reset.
- h_sync  in  1  active-low horizontal sync.
- v_sync  in  1  active-low vertical sync.
- red  in  3, green  in  3, blue  in  2: pixel colour.
- wr_en  out  1  framebuffer write strobe.
- wr_addr  out  20  {py[9:0], px[9:0]}.
- wr_data  out  8  {red, green, blue}.
- locked  out  1  timing verified; writes enabled.
- frame_done  out  1  one-cycle pulse coincident with the write to {479, 639}.
- sync_error  out  1  one-cycle pulse on a timing violation (CHECK/LOCKED only).

## Operation
- Input stage: h_sync, v_sync and RGB are registered together in one stage. All following rules refer to these registered samples.
- Sample x (11 b): 0 on the first low h_sync sample (h falling edge); otherwise previous x+1, saturating at H_WHOLE_LINE.
- Line y (10 b): 0 on frame start; +1 on each other h falling edge; saturating at V_WHOLE_FRAME.
- Frame start: a sample where h_sync and v_sync both fall.
- Visible window:
  - XS = H_SYNC_PULSE+H_FRONT_PORCH+PIXEL_DELAY (113); YS = V_SYNC_PULSE+V_FRONT_PORCH (12).
  - A sample is visible when XS ≤ x < XS+640 and YS ≤ y < YS+480.
  - px = x−XS, py = y−YS.
- Violations (each raises sync_error):
  - h falling edge whose previous sample x ≠ H_WHOLE_LINE−1.
  - x reaches H_WHOLE_LINE.
  - First high h sample with x ≠ H_SYNC_PULSE.
  - Frame start whose previous line y ≠ V_WHOLE_FRAME−1.
  - y reaches V_WHOLE_FRAME.
  - v_sync rising at a line start with y ≠ V_SYNC_PULSE, or v_sync changing on a sample that is not an h falling edge.
- FSM:
  - SEARCH: no writes, no errors reported. On frame start go to CHECK.
  - CHECK: no writes. On a violation, pulse sync_error and go to SEARCH. On the next frame start, go to LOCKED.
  - LOCKED: locked=1; wr_en for every visible sample. On a violation, pulse sync_error, drop locked and wr_en in the same cycle, and go to SEARCH.
- Simultaneous events: a violation detected on a frame-start sample takes priority over the CHECK→LOCKED transition; the block goes to SEARCH.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, locked=0, frame_done=0, sync_error=0; FSM=SEARCH; x and y saturated at their maxima.
- Latency: 2 cycles from pins to outputs (input register + output register).
- wr_addr and wr_data are registered alongside wr_en. They are don't-care while wr_en=0 but hold their last value.
- locked rises in the output cycle of the frame-start sample that enters LOCKED. The first write of a locked frame is {12 lines later, addr 0}.
- sync_error and locked fall in the output cycle of the violating sample. No write is issued for that sample.
- Relock: at least one CHECK frame is required, so the minimum is 2 frame starts after the stream is restored.
- Reset mid-frame clears all state immediately (asynchronous). Capture restarts from SEARCH on release.

## Structure
- Shared package vga_pkg holds:
  - the timing defaults and derived XS/YS/H_WHOLE_LINE/V_WHOLE_FRAME;
  - the 20-bit address typedef;
  - the state enum (SEARCH, CHECK, LOCKED).
- The VGA generator should adopt the same package.
- One sub-module, vga_sync_edge: registered sample plus previous-sample flop for one sync line, giving fall/rise pulses. It is instantiated twice, once for h_sync and once for v_sync.

## Test plan
- Reset: hold rst with random inputs → all outputs 0. Release mid-line → no write and no error until the second frame start.
- Loopback from the generator with data = px[7:0] → locked rises at frame 2. Each frame has exactly 307200 writes, and wr_data == wr_addr[7:0] for every write. frame_done fires once per frame with wr_addr = {479, 639}.
- Line length 801 on line 200 while locked → one sync_error pulse, locked=0, no further writes. Relock after 2 clean frame starts.
- h_sync pulse width of 95 during CHECK → sync_error pulse, stays unlocked, returns to SEARCH. The same fault in SEARCH → no pulse.
- Frame of 526 lines → sync_error when y reaches 525, with no write after it.
- Assert rst during visible line 100 → wr_en and locked fall asynchronously. After release the block recovers to locked in 2 frames.
